// File: rtl/dmem_line_responder_pkg.sv
// -----------------------------------------------------------------------------
// dmem_line_responder_pkg
// Shared LC-3b memory-side types used by the data-memory line responder and
// its line store.
//   lc3b_word       16-bit CPU word / byte address
//   lc3b_data       128-bit cache line
//   lc3b_mem_wmask  2-bit byte enable, bit0 = low byte
//   lc3b_line_tag   line address (address bits above the line offset)
// -----------------------------------------------------------------------------
package dmem_line_responder_pkg;

  localparam int LINE_OFFSET_BITS = 4;

  typedef logic [15:0]                  lc3b_word;
  typedef logic [127:0]                 lc3b_data;
  typedef logic [1:0]                   lc3b_mem_wmask;
  typedef logic [15:LINE_OFFSET_BITS]   lc3b_line_tag;

endpackage : dmem_line_responder_pkg

// File: rtl/dmem_line_responder_line_array.sv
// -----------------------------------------------------------------------------
// line_array
// Direct-mapped line store: data, tag, valid and dirty per line.
//   clk, rst          clock, synchronous active-high reset (valid/dirty only)
//   idx_i             line index for both the combinational read and the write
//   data_o/tag_o      stored line data and tag at idx_i
//   valid_o/dirty_o   stored status bits at idx_i
//   *_we_i / *_i      independent load strobes and write values
// -----------------------------------------------------------------------------
module line_array
  import dmem_line_responder_pkg::*;
#(
  parameter int LINES = 8,
  parameter int TAG_W = 9
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [$clog2(LINES)-1:0]  idx_i,
  output lc3b_data                  data_o,
  output logic [TAG_W-1:0]          tag_o,
  output logic                      valid_o,
  output logic                      dirty_o,
  input  logic                      data_we_i,
  input  lc3b_data                  data_i,
  input  logic                      tag_we_i,
  input  logic [TAG_W-1:0]          tag_i,
  input  logic                      valid_we_i,
  input  logic                      valid_i,
  input  logic                      dirty_we_i,
  input  logic                      dirty_i
);

  lc3b_data           data_q [LINES];
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [LINES-1:0]   valid_q;
  logic [LINES-1:0]   dirty_q;

  // NOTE: data and tag storage has no reset; valid gates every use of it, so
  // resetting wide storage would only cost flops and fan-out.
  always_ff @(posedge clk) begin
    if (data_we_i) data_q[idx_i] <= data_i;
    if (tag_we_i)  tag_q[idx_i]  <= tag_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (valid_we_i) valid_q[idx_i] <= valid_i;
      if (dirty_we_i) dirty_q[idx_i] <= dirty_i;
    end
  end

  assign data_o  = data_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];

endmodule : line_array

// File: rtl/dmem_line_responder.sv
// -----------------------------------------------------------------------------
// dmem_line_responder
// Responder for the CPU data-memory strobe/cycle interface, backed by a small
// direct-mapped write-back line store; misses go out over the line-wide pmem
// port (optional write-back of a dirty victim, then a fill).
//   clk, rst                 clock, synchronous active-high reset
//   mem_action_stb/_cyc      request exists when both are high
//   mem_write, mem_address,
//   mem_wdata, mem_byte_enable  request fields
//   mem_rdata                registered line containing the address
//   mem_resp                 one-cycle completion pulse
//   mem_retry                request present while a miss is in service
//   pmem_*                   line-wide physical memory port
// -----------------------------------------------------------------------------
module dmem_line_responder
  import dmem_line_responder_pkg::*;
#(
  parameter int LINES = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mem_action_stb,
  input  logic           mem_action_cyc,
  input  logic           mem_write,
  input  lc3b_word       mem_address,
  input  lc3b_word       mem_wdata,
  input  lc3b_mem_wmask  mem_byte_enable,
  output lc3b_data       mem_rdata,
  output logic           mem_resp,
  output logic           mem_retry,
  output lc3b_word       pmem_address,
  output logic           pmem_read,
  output logic           pmem_write,
  output lc3b_data       pmem_wdata,
  input  lc3b_data       pmem_rdata,
  input  logic           pmem_resp
);

  localparam int IDX   = $clog2(LINES);
  localparam int TAG_W = 16 - LINE_OFFSET_BITS - IDX;

  typedef enum logic [1:0] {S_IDLE, S_RESP, S_WB, S_FILL} state_e;

  state_e            state_q, state_d;
  lc3b_data          rdata_q, rdata_d;
  logic [IDX-1:0]    idx_q, idx_d;
  logic [TAG_W-1:0]  tag_q, tag_d;

  logic              req;
  logic [IDX-1:0]    addr_idx, arr_idx;
  logic [TAG_W-1:0]  addr_tag, arr_tag;
  logic [2:0]        wsel;
  lc3b_data          arr_data, merged;
  logic              arr_valid, arr_dirty, hit;

  logic              data_we, tag_we, valid_we, dirty_we, valid_wr, dirty_wr;
  lc3b_data          data_wr;

  logic              unused_addr_bit;
  assign unused_addr_bit = mem_address[0];

  assign req      = mem_action_stb & mem_action_cyc;
  assign addr_idx = mem_address[LINE_OFFSET_BITS +: IDX];
  assign addr_tag = mem_address[15 -: TAG_W];
  assign wsel     = mem_address[3:1];
  // In IDLE the store is looked up with the live address; during a miss it
  // follows the latched index so the victim and the fill target stay put.
  assign arr_idx  = (state_q == S_IDLE) ? addr_idx : idx_q;
  assign hit      = arr_valid & (arr_tag == addr_tag);

  line_array #(.LINES(LINES), .TAG_W(TAG_W)) u_line_array (
    .clk        (clk),
    .rst        (rst),
    .idx_i      (arr_idx),
    .data_o     (arr_data),
    .tag_o      (arr_tag),
    .valid_o    (arr_valid),
    .dirty_o    (arr_dirty),
    .data_we_i  (data_we),
    .data_i     (data_wr),
    .tag_we_i   (tag_we),
    .tag_i      (tag_q),
    .valid_we_i (valid_we),
    .valid_i    (valid_wr),
    .dirty_we_i (dirty_we),
    .dirty_i    (dirty_wr)
  );

  // Byte merge of the write word into the addressed 16-bit word of the line.
  always_comb begin
    merged = arr_data;
    if (mem_byte_enable[0]) merged[{wsel, 4'h0} +: 8] = mem_wdata[7:0];
    if (mem_byte_enable[1]) merged[{wsel, 4'h8} +: 8] = mem_wdata[15:8];
  end

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rdata_q <= '0;
      idx_q   <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      idx_q   <= idx_d;
      tag_q   <= tag_d;
    end
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (req) state_d = hit ? S_RESP : ((arr_valid & arr_dirty) ? S_WB : S_FILL);
      S_RESP: state_d = S_IDLE;
      S_WB:   if (pmem_resp) state_d = S_FILL;
      S_FILL: if (pmem_resp) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output, array-strobe and datapath next-value logic.
  always_comb begin
    data_we      = 1'b0;
    data_wr      = pmem_rdata;
    tag_we       = 1'b0;
    valid_we     = 1'b0;
    valid_wr     = 1'b1;
    dirty_we     = 1'b0;
    dirty_wr     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    rdata_d      = rdata_q;
    idx_d        = idx_q;
    tag_d        = tag_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          if (hit) begin
            rdata_d = mem_write ? merged : arr_data;
            if (mem_write) begin
              data_we  = 1'b1;
              data_wr  = merged;
              dirty_we = 1'b1;
              dirty_wr = 1'b1;
            end
          end else begin
            idx_d = addr_idx;
            tag_d = addr_tag;
          end
        end
      end
      S_WB: begin
        pmem_write   = 1'b1;
        pmem_address = {arr_tag, idx_q, 4'h0};
        if (pmem_resp) dirty_we = 1'b1;
      end
      S_FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {tag_q, idx_q, 4'h0};
        if (pmem_resp) begin
          data_we  = 1'b1;
          tag_we   = 1'b1;
          valid_we = 1'b1;
          dirty_we = 1'b1;
        end
      end
      default: ;
    endcase
    // Reset wins over any store update requested in the same cycle.
    if (rst) begin
      data_we  = 1'b0;
      tag_we   = 1'b0;
      valid_we = 1'b0;
      dirty_we = 1'b0;
    end
  end

  assign pmem_wdata = arr_data;
  assign mem_rdata  = rdata_q;
  assign mem_resp   = (state_q == S_RESP);
  assign mem_retry  = req & ((state_q == S_WB) | (state_q == S_FILL));

endmodule : dmem_line_responder
